day_calendar: RTL
=================

# day_calendar

Calendar unit for the watch controller: tracks day-of-week, day-of-month and month, advancing once per `dayTick` strobe from the time-of-day counter at midnight rollover. It drives four registered letter codes for the day-name display in the shared character encoding, plus numeric date and month to the display mux. It replaces the fixed-width, self-clocked day display with a single-clock, parametrised block that adds date/month tracking, leap-year handling, validated loading and rollover pulses.

## Interface
Parameters:
- `LETTER_W`, 4: letter code width (≥4); codes zero-extended.
- `RESET_DAY`, 0: day-of-week after reset (0=MON … 6=SUN).
- `RESET_DATE`, 1: day-of-month after reset (1..31, valid for `RESET_MONTH`).
- `RESET_MONTH`, 1: month after reset (1..12).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetTime_n`  in  1  reset, asynchronous, active-low.
- `dayTick`  in  1  one-cycle strobe: advance one day.
- `stop`  in  1  hold; while high, `dayTick` is ignored (not queued).
- `setValue`  in  1  one-cycle load strobe.
- `curDay`  in  3  day-of-week to load.
- `curDate`  in  5  day-of-month to load.
- `curMonth`  in  4  month to load.
- `leapYear`  in  1  level; current year is leap (Feb = 29 days).
- `dayOfWeek`  out  3  0..6.
- `date`  out  5  1..31.
- `month`  out  4  1..12.
- `FirstLetter`, `SecondLetter`, `ThirdLetter`, `FourthLetter`  out  LETTER_W each  day-name codes.
- `monthEnd`  out  1  one-cycle pulse on month rollover.
- `yearEnd`  out  1  one-cycle pulse on Dec 31 → Jan 1.
- `setErr`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Priority per edge: reset > `setValue` > `stop` > `dayTick`.
- Advance (`dayTick`=1, `stop`=0, `setValue`=0): `dayOfWeek` = 6 → 0 else +1. `date` = monthLen → 1 with `month` +1 (12 → 1) else `date`+1.
- monthLen: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 28, or 29 if `leapYear`. `leapYear` sampled on the advancing edge.
- Load: accepted only if `curDay` ≤ 6, 1 ≤ `curMonth` ≤ 12, and 1 ≤ `curDate` ≤ monthLen(`curMonth`, `leapYear`). Accepted: all three registers load together. Rejected: nothing changes, `setErr` pulses. A coincident `dayTick` is dropped in either case.
- Letter encoding: SPACE=0, A=1, D=2, E=3, F=4, H=5, I=6, N=7, O=8, P=9, R=A, S=B, T=C, U=D, M=E, W=F.
- Day names, four letters: MON␠, TUE␠, WED␠, THU␠, FRI␠, SAT␠, SUN␠ (FourthLetter = SPACE).
- Letters are registered and decoded from the next-state day. Letters and `dayOfWeek` always change on the same edge and are never mismatched.
- `monthEnd` pulses on the edge where `date` wraps to 1. `yearEnd` pulses on the same edge when `month` wraps 12 → 1. Both are 0 at all other times, including after loads.
- FSM: day-of-week is a 7-state ring (MON…SUN). Encodings 7 and above are unreachable; if ever present, the next advance goes to MON.

## Timing
- Reset (async assert, sync-released by the top level): `dayOfWeek`=RESET_DAY, `date`=RESET_DATE, `month`=RESET_MONTH, letters = name of RESET_DAY, `monthEnd`=`yearEnd`=`setErr`=0.
- Reset mid-operation overrides any in-flight tick or load. No pulse is emitted on reset.
- Latency: `dayTick` or `setValue` sampled at edge n → all outputs valid after edge n (one cycle).
- Back-to-back `dayTick` on consecutive cycles: each one advances.
- `dayTick` held high for k cycles advances k days. The tick generator guarantees single-cycle strobes.
- Pulses are exactly one cycle wide.

## Test plan
- Reset with defaults: `resetTime_n` low → `dayOfWeek`=0, `date`=1, `month`=1, letters = E,8,7,0 (MON␠), all pulses 0.
- Week wrap: load day 6, date 10, month 3, then one `dayTick` → day 0, date 11, letters E,8,7,0, no `monthEnd`.
- Feb rollover: load (2, 28, 2) with `leapYear`=0, tick → date 1, month 3, `monthEnd` high one cycle. Repeat with `leapYear`=1 → date 29, month 2, no pulse.
- Year end: load (4, 31, 12), tick → day 5 (SAT␠ = B,1,C,0), date 1, month 1, `monthEnd` and `yearEnd` high together for one cycle.
- Invalid load: `setValue` with (3, 31, 4) → `setErr` one cycle, state unchanged. `setValue` with curDay=7 → `setErr`.
- Priority: `stop`=1 with `dayTick` → no change. `setValue` and `dayTick` on the same cycle → loaded value only. `resetTime_n` asserted mid-tick → reset values immediately, asynchronously.

Source files
------------

// File: rtl/day_calendar.sv
// -----------------------------------------------------------------------------
// day_calendar
// Calendar unit for the watch controller. Tracks day-of-week, day-of-month and
// month. It advances once per dayTick strobe and supports a validated parallel
// load. It also drives four registered letter codes naming the current day for
// the character display.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   resetTime_n   asynchronous active-low reset
//   dayTick       one-cycle strobe: advance one day
//   stop          hold; dayTick is ignored (not queued) while high
//   setValue      one-cycle load strobe for curDay/curDate/curMonth
//   curDay        day-of-week to load (0=MON..6=SUN)
//   curDate       day-of-month to load (1..31)
//   curMonth      month to load (1..12)
//   leapYear      level: current year is leap (February has 29 days)
//   dayOfWeek     current day-of-week (0..6)
//   date          current day-of-month (1..31)
//   month         current month (1..12)
//   FirstLetter..FourthLetter  day-name letter codes, zero-extended to LETTER_W
//   monthEnd      one-cycle pulse when date wraps to 1
//   yearEnd       one-cycle pulse when month wraps 12 -> 1
//   setErr        one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module day_calendar #(
  parameter int LETTER_W    = 4,
  parameter int RESET_DAY   = 0,
  parameter int RESET_DATE  = 1,
  parameter int RESET_MONTH = 1
) (
  input  logic                clk,
  input  logic                resetTime_n,
  input  logic                dayTick,
  input  logic                stop,
  input  logic                setValue,
  input  logic [2:0]          curDay,
  input  logic [4:0]          curDate,
  input  logic [3:0]          curMonth,
  input  logic                leapYear,
  output logic [2:0]          dayOfWeek,
  output logic [4:0]          date,
  output logic [3:0]          month,
  output logic [LETTER_W-1:0] FirstLetter,
  output logic [LETTER_W-1:0] SecondLetter,
  output logic [LETTER_W-1:0] ThirdLetter,
  output logic [LETTER_W-1:0] FourthLetter,
  output logic                monthEnd,
  output logic                yearEnd,
  output logic                setErr
);

  typedef enum logic [2:0] {
    MON = 3'd0,
    TUE = 3'd1,
    WED = 3'd2,
    THU = 3'd3,
    FRI = 3'd4,
    SAT = 3'd5,
    SUN = 3'd6
  } day_t;

  // Shared character encoding
  localparam logic [3:0] L_SP = 4'h0;
  localparam logic [3:0] L_A  = 4'h1;
  localparam logic [3:0] L_D  = 4'h2;
  localparam logic [3:0] L_E  = 4'h3;
  localparam logic [3:0] L_F  = 4'h4;
  localparam logic [3:0] L_H  = 4'h5;
  localparam logic [3:0] L_I  = 4'h6;
  localparam logic [3:0] L_N  = 4'h7;
  localparam logic [3:0] L_O  = 4'h8;
  localparam logic [3:0] L_R  = 4'hA;
  localparam logic [3:0] L_S  = 4'hB;
  localparam logic [3:0] L_T  = 4'hC;
  localparam logic [3:0] L_U  = 4'hD;
  localparam logic [3:0] L_M  = 4'hE;
  localparam logic [3:0] L_W  = 4'hF;

  // Number of days in month m; 0 for an invalid month so no date can fit it.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    logic [4:0] len;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
      4'd2:                                       len = leap ? 5'd29 : 5'd28;
      default:                                    len = 5'd0;
    endcase
    return len;
  endfunction

  // Four 4-bit letter codes {first, second, third, fourth} naming a day.
  function automatic logic [15:0] day_name(input day_t d);
    logic [15:0] name;
    case (d)
      MON:     name = {L_M, L_O, L_N, L_SP};
      TUE:     name = {L_T, L_U, L_E, L_SP};
      WED:     name = {L_W, L_E, L_D, L_SP};
      THU:     name = {L_T, L_H, L_U, L_SP};
      FRI:     name = {L_F, L_R, L_I, L_SP};
      SAT:     name = {L_S, L_A, L_T, L_SP};
      SUN:     name = {L_S, L_U, L_N, L_SP};
      default: name = {L_SP, L_SP, L_SP, L_SP};
    endcase
    return name;
  endfunction

  localparam day_t        RST_DAY   = day_t'(RESET_DAY[2:0]);
  localparam logic [4:0]  RST_DATE  = RESET_DATE[4:0];
  localparam logic [3:0]  RST_MONTH = RESET_MONTH[3:0];
  localparam logic [15:0] RST_NAME  = day_name(RST_DAY);

  day_t        day_r, day_nxt;
  logic [4:0]  date_r, date_nxt;
  logic [3:0]  month_r, month_nxt;
  logic [15:0] letters_nxt;
  logic [LETTER_W-1:0] first_r, second_r, third_r, fourth_r;
  logic        month_end_r, month_end_nxt;
  logic        year_end_r, year_end_nxt;
  logic        set_err_r, set_err_nxt;
  logic        load_ok;
  logic [4:0]  cur_len;
  logic [4:0]  adv_len;

  // Next-state logic: load/stop/advance priority, day ring and date/month rollover
  always_comb begin
    day_nxt       = day_r;
    date_nxt      = date_r;
    month_nxt     = month_r;
    month_end_nxt = 1'b0;
    year_end_nxt  = 1'b0;
    set_err_nxt   = 1'b0;
    cur_len       = month_len(curMonth, leapYear);
    adv_len       = month_len(month_r, leapYear);
    load_ok       = (curDay <= 3'd6) && (curMonth >= 4'd1) && (curMonth <= 4'd12) &&
                    (curDate >= 5'd1) && (curDate <= cur_len);

    if (setValue) begin
      // A coincident dayTick is dropped whether or not the load is accepted.
      if (load_ok) begin
        day_nxt   = day_t'(curDay);
        date_nxt  = curDate;
        month_nxt = curMonth;
      end else begin
        set_err_nxt = 1'b1;
      end
    end else if (stop) begin
      day_nxt   = day_r;
      date_nxt  = date_r;
      month_nxt = month_r;
    end else if (dayTick) begin
      case (day_r)
        MON:     day_nxt = TUE;
        TUE:     day_nxt = WED;
        WED:     day_nxt = THU;
        THU:     day_nxt = FRI;
        FRI:     day_nxt = SAT;
        SAT:     day_nxt = SUN;
        SUN:     day_nxt = MON;
        default: day_nxt = MON;  // unreachable encoding recovers to MON
      endcase
      // >= rather than == so a corrupted date still rolls over
      if (date_r >= adv_len) begin
        date_nxt      = 5'd1;
        month_end_nxt = 1'b1;
        if (month_r >= 4'd12) begin
          month_nxt    = 4'd1;
          year_end_nxt = 1'b1;
        end else begin
          month_nxt = month_r + 4'd1;
        end
      end else begin
        date_nxt = date_r + 5'd1;
      end
    end else begin
      day_nxt   = day_r;
      date_nxt  = date_r;
      month_nxt = month_r;
    end

    // Letters decode the next-state day so they update with dayOfWeek.
    letters_nxt = day_name(day_nxt);
  end

  // State, letter and pulse registers
  always_ff @(posedge clk or negedge resetTime_n) begin
    if (!resetTime_n) begin
      day_r       <= RST_DAY;
      date_r      <= RST_DATE;
      month_r     <= RST_MONTH;
      first_r     <= LETTER_W'(RST_NAME[15:12]);
      second_r    <= LETTER_W'(RST_NAME[11:8]);
      third_r     <= LETTER_W'(RST_NAME[7:4]);
      fourth_r    <= LETTER_W'(RST_NAME[3:0]);
      month_end_r <= 1'b0;
      year_end_r  <= 1'b0;
      set_err_r   <= 1'b0;
    end else begin
      day_r       <= day_nxt;
      date_r      <= date_nxt;
      month_r     <= month_nxt;
      first_r     <= LETTER_W'(letters_nxt[15:12]);
      second_r    <= LETTER_W'(letters_nxt[11:8]);
      third_r     <= LETTER_W'(letters_nxt[7:4]);
      fourth_r    <= LETTER_W'(letters_nxt[3:0]);
      month_end_r <= month_end_nxt;
      year_end_r  <= year_end_nxt;
      set_err_r   <= set_err_nxt;
    end
  end

  assign dayOfWeek    = day_r;
  assign date         = date_r;
  assign month        = month_r;
  assign FirstLetter  = first_r;
  assign SecondLetter = second_r;
  assign ThirdLetter  = third_r;
  assign FourthLetter = fourth_r;
  assign monthEnd     = month_end_r;
  assign yearEnd      = year_end_r;
  assign setErr       = set_err_r;

endmodule
